// File: rtl/nibble_serial_sub.sv
// Multi-cycle subtractor: DIFF = A - B - bin, one 4-bit lookahead slice per clock,
// least-significant nibble first, with valid/ready handshakes on both sides.
module nibble_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg, nb_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_slice;

    logic [3:0]       g, p, c, s;
    logic             c4;
    logic [CW+1:0]    base;
    logic [WIDTH-1:0] diff_next;

    assign last_slice = (cnt == LAST);
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);

    // Operand registers shift right each RUN cycle, so the active slice is always bits [3:0].
    assign g = a_reg[3:0] & nb_reg[3:0];
    assign p = a_reg[3:0] ^ nb_reg[3:0];

    always_comb begin
        c[0] = carry;
        c[1] = g[0] | (p[0] & carry);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
        c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry);
        s    = p ^ c;
    end

    // The zero flag must see the nibble being written this cycle, so assemble it ahead of the register.
    assign base = {cnt, 2'b00};

    always_comb begin
        diff_next = diff;
        diff_next[base +: 4] = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)   state_next = RUN;
            RUN:  if (last_slice) state_next = DONE;
            DONE: if (out_ready)  state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            nb_reg <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= a;
                        nb_reg <= ~b;
                        carry  <= ~bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_reg  <= a_reg >> 4;
                    nb_reg <= nb_reg >> 4;
                    carry  <= c4;
                    diff   <= diff_next;
                    if (last_slice) begin
                        bout <= ~c4;
                        ovf  <= c[3] ^ c4;
                        zero <= (diff_next == '0);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub: scoreboard of reference results for the
// 16-bit instance plus directed latency, backpressure, reset-abort and 4-bit width tests.
module tb_nibble_serial_sub;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, bin, out_ready;
    logic [15:0] a, b;
    logic        in_ready, out_valid, bout, ovf, zero;
    logic [15:0] diff;

    logic        in_valid4, bin4, out_ready4;
    logic [3:0]  a4, b4;
    logic        in_ready4, out_valid4, bout4, ovf4, zero4;
    logic [3:0]  diff4;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct packed {
        logic [3:0] diff;
        logic       bout;
        logic       ovf;
        logic       zero;
    } res4_t;

    res_t  q[$];
    res4_t q4[$];

    nibble_serial_sub #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    nibble_serial_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .bout(bout4), .ovf(ovf4), .zero(zero4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic res_t model16(input logic [15:0] av, input logic [15:0] bv, input logic binv);
        logic [16:0] full;
        res_t r;
        full   = {1'b0, av} - {1'b0, bv} - {16'd0, binv};
        r.diff = full[15:0];
        r.bout = full[16];
        r.ovf  = (av[15] != bv[15]) && (r.diff[15] != av[15]);
        r.zero = (r.diff == 16'd0);
        return r;
    endfunction

    function automatic res4_t model4(input logic [3:0] av, input logic [3:0] bv, input logic binv);
        logic [4:0] full;
        res4_t r;
        full   = {1'b0, av} - {1'b0, bv} - {4'd0, binv};
        r.diff = full[3:0];
        r.bout = full[4];
        r.ovf  = (av[3] != bv[3]) && (r.diff[3] != av[3]);
        r.zero = (r.diff == 4'd0);
        return r;
    endfunction

    // Scoreboard: every completed output handshake of the 16-bit instance is checked here.
    always @(negedge clk) begin
        res_t e, o;
        if (rst_n && out_valid && out_ready) begin
            o = {diff, bout, ovf, zero};
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("[TB] FAIL scoreboard_unexpected actual=%h required=none", o);
            end else begin
                e = q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("[TB] FAIL scoreboard_result actual diff=%h bout=%b ovf=%b zero=%b required diff=%h bout=%b ovf=%b zero=%b",
                             o.diff, o.bout, o.ovf, o.zero, e.diff, e.bout, e.ovf, e.zero);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair, push its reference result, and wait for out_valid (bounded).
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic binv,
                         output int lat, output time tacc);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        a = av; b = bv; bin = binv; in_valid = 1'b1;
        tick();
        tacc = $time;
        q.push_back(model16(av, bv, binv));
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; bin = 1'b1;
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0; out_ready4 = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, diff, bout, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            failures++;
            $display("[TB] FAIL reset16 actual rdy=%b vld=%b diff=%h flags=%b%b%b required rdy=1 vld=0 diff=0000 flags=000",
                     in_ready, out_valid, diff, bout, ovf, zero);
        end
        checks++;
        if ({in_ready4, out_valid4, diff4, bout4, ovf4, zero4} !== {1'b1, 1'b0, 4'h0, 3'b000}) begin
            failures++;
            $display("[TB] FAIL reset4 actual rdy=%b vld=%b diff=%h flags=%b%b%b required rdy=1 vld=0 diff=0 flags=000",
                     in_ready4, out_valid4, diff4, bout4, ovf4, zero4);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        time t;
        do_op(16'h1234, 16'h0034, 1'b0, lat, t);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("[TB] FAIL basic_latency actual=%0d required=4", lat);
        end
        ack();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_valid_drop actual=%b required=0", out_valid);
        end
    endtask

    task automatic test_underflow();
        int lat;
        time t;
        do_op(16'h0000, 16'h0001, 1'b0, lat, t);
        ack();
    endtask

    task automatic test_overflow();
        int lat;
        time t;
        do_op(16'h8000, 16'h0001, 1'b0, lat, t);
        ack();
        do_op(16'h7FFF, 16'hFFFF, 1'b0, lat, t);
        ack();
    endtask

    task automatic test_zero_borrow();
        int lat;
        time t;
        do_op(16'h5555, 16'h5555, 1'b0, lat, t);
        ack();
        do_op(16'h5555, 16'h5555, 1'b1, lat, t);
        ack();
    endtask

    task automatic test_backpressure();
        int lat;
        time t;
        logic [18:0] snap;
        do_op(16'hA5C3, 16'h1F2E, 1'b1, lat, t);
        snap = {diff, bout, ovf, zero};
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 16'hFFFF; b = 16'h0000; bin = 1'b0; in_valid = 1'b1;
            end
            if (i == 4) in_valid = 1'b0;
            tick();
            checks++;
            if ({out_valid, in_ready, diff, bout, ovf, zero} !== {2'b10, snap}) begin
                failures++;
                $display("[TB] FAIL hold_cycle%0d actual vld=%b rdy=%b res=%h required vld=1 rdy=0 res=%h",
                         i, out_valid, in_ready, {diff, bout, ovf, zero}, snap);
            end
        end
        ack();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL release_handshake actual vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
        do_op(16'h0F0F, 16'h00FF, 1'b0, lat, t);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("[TB] FAIL after_hold_latency actual=%0d required=4", lat);
        end
        ack();
    endtask

    task automatic test_reset_midrun();
        int lat;
        time t;
        int stray;
        a = 16'h9876; b = 16'h1234; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        q.delete();
        checks++;
        if ({out_valid, in_ready, diff, bout, ovf, zero} !== {2'b01, 16'h0, 3'b000}) begin
            failures++;
            $display("[TB] FAIL midrun_reset actual vld=%b rdy=%b diff=%h flags=%b%b%b required vld=0 rdy=1 diff=0000 flags=000",
                     out_valid, in_ready, diff, bout, ovf, zero);
        end
        tick();
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("[TB] FAIL stray_valid actual=%0d required=0", stray);
        end
        do_op(16'h1234, 16'h0034, 1'b0, lat, t);
        ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        time t, tprev;
        logic [15:0] ra, rb;
        out_ready = 1'b1;
        tprev = 0;
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            do_op(ra, rb, 1'($urandom_range(0, 1)), lat, t);
            if (i > 0) begin
                checks++;
                if (t - tprev !== 60) begin
                    failures++;
                    $display("[TB] FAIL throughput op%0d actual=%0t required=60", i, t - tprev);
                end
            end
            tprev = t;
            tick();
        end
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_width4();
        logic [3:0] av [2];
        logic [3:0] bv [2];
        res4_t e, o;
        av[0] = 4'h3; bv[0] = 4'h5;
        av[1] = 4'h8; bv[1] = 4'h1;
        for (int i = 0; i < 2; i++) begin
            a4 = av[i]; b4 = bv[i]; bin4 = 1'b0; in_valid4 = 1'b1;
            tick();
            q4.push_back(model4(av[i], bv[i], 1'b0));
            in_valid4 = 1'b0;
            checks++;
            if (out_valid4 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL w4_early_valid op%0d actual=%b required=0", i, out_valid4);
            end
            tick();
            checks++;
            if (out_valid4 !== 1'b1) begin
                failures++;
                $display("[TB] FAIL w4_latency op%0d actual=%b required=1", i, out_valid4);
            end
            o = {diff4, bout4, ovf4, zero4};
            e = q4.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL w4_result op%0d actual diff=%h bout=%b ovf=%b zero=%b required diff=%h bout=%b ovf=%b zero=%b",
                         i, o.diff, o.bout, o.ovf, o.zero, e.diff, e.bout, e.ovf, e.zero);
            end
            out_ready4 = 1'b1;
            tick();
            out_ready4 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_overflow();
        test_zero_borrow();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        test_width4();
        repeat (2) tick();
        checks++;
        if (q.size() !== 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
